// File: rtl/tmds_decoder.sv
// TMDS receive channel: finds the word boundary by requesting bit-slips until
// control tokens are seen reliably, then decodes video data and control symbols.
module tmds_decoder #(
    parameter int LOCK_COUNT    = 8,
    parameter int SEARCH_WINDOW = 4096,
    parameter int SLIP_SETTLE   = 16,
    parameter int LOSS_WINDOW   = 65536
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [9:0] i_word,
    output logic [7:0] o_data,
    output logic [1:0] o_control,
    output logic       o_ve,
    output logic       o_locked,
    output logic       o_bitslip
);

    localparam int TW = $clog2(LOCK_COUNT) + 1;
    localparam int WW = $clog2(SEARCH_WINDOW) + 1;
    localparam int SW = $clog2(SLIP_SETTLE) + 1;
    localparam int GW = $clog2(LOSS_WINDOW) + 1;

    localparam logic [TW-1:0] TOK_LAST    = TW'(LOCK_COUNT - 1);
    localparam logic [WW-1:0] WIN_LAST    = WW'(SEARCH_WINDOW - 1);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SLIP_SETTLE - 1);
    localparam logic [GW-1:0] GAP_LAST    = GW'(LOSS_WINDOW - 1);

    typedef enum logic [1:0] {
        SEARCH    = 2'd0,
        SLIP_WAIT = 2'd1,
        LOCKED    = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_nextState;
    logic [TW-1:0]   r_tokCnt, w_tokCnt;
    logic [WW-1:0]   r_winCnt, w_winCnt;
    logic [SW-1:0]   r_settleCnt, w_settleCnt;
    logic [GW-1:0]   r_gapCnt, w_gapCnt;
    logic            w_slip;

    logic            w_isTok;
    logic [1:0]      w_tokVal;
    logic [8:0]      w_d;
    logic [7:0]      w_q;

    logic [7:0]      r_data;
    logic [1:0]      r_control;
    logic            r_ve;
    logic            r_locked;
    logic            r_bitslip;

    always_comb begin
        w_isTok  = 1'b1;
        w_tokVal = 2'b00;
        case (i_word)
            10'b1101010100: w_tokVal = 2'b00;
            10'b0010101011: w_tokVal = 2'b01;
            10'b0101010100: w_tokVal = 2'b10;
            10'b1010101011: w_tokVal = 2'b11;
            default:        w_isTok  = 1'b0;
        endcase
    end

    // Undo the optional inversion, then the XOR/XNOR transition chain.
    always_comb begin
        w_d    = i_word[9] ? {i_word[8], ~i_word[7:0]} : i_word[8:0];
        w_q    = 8'h00;
        w_q[0] = w_d[0];
        for (int i = 1; i < 8; i++) begin
            w_q[i] = w_d[8] ? (w_d[i] ^ w_d[i-1]) : ~(w_d[i] ^ w_d[i-1]);
        end
    end

    always_comb begin
        w_nextState = r_state;
        w_tokCnt    = r_tokCnt;
        w_winCnt    = r_winCnt;
        w_settleCnt = r_settleCnt;
        w_gapCnt    = r_gapCnt;
        w_slip      = 1'b0;
        case (r_state)
            SEARCH: begin
                w_tokCnt = w_isTok ? ((r_tokCnt == '1) ? r_tokCnt : r_tokCnt + 1'b1) : '0;
                w_winCnt = (r_winCnt == '1) ? r_winCnt : r_winCnt + 1'b1;
                // A lock on this word takes priority over an expiring window.
                if (w_isTok && r_tokCnt == TOK_LAST) begin
                    w_nextState = LOCKED;
                    w_tokCnt    = '0;
                    w_winCnt    = '0;
                    w_gapCnt    = '0;
                end else if (r_winCnt == WIN_LAST) begin
                    w_nextState = SLIP_WAIT;
                    w_slip      = 1'b1;
                    w_tokCnt    = '0;
                    w_winCnt    = '0;
                    w_settleCnt = '0;
                end
            end
            SLIP_WAIT: begin
                if (r_settleCnt == SETTLE_LAST) begin
                    w_nextState = SEARCH;
                    w_settleCnt = '0;
                    w_tokCnt    = '0;
                    w_winCnt    = '0;
                end else begin
                    w_settleCnt = r_settleCnt + 1'b1;
                end
            end
            LOCKED: begin
                if (w_isTok) begin
                    w_gapCnt = '0;
                end else if (r_gapCnt == GAP_LAST) begin
                    w_nextState = SEARCH;
                    w_gapCnt    = '0;
                    w_tokCnt    = '0;
                    w_winCnt    = '0;
                end else begin
                    w_gapCnt = (r_gapCnt == '1) ? r_gapCnt : r_gapCnt + 1'b1;
                end
            end
            default: begin
                w_nextState = SEARCH;
                w_tokCnt    = '0;
                w_winCnt    = '0;
                w_settleCnt = '0;
                w_gapCnt    = '0;
            end
        endcase
    end

    // Outputs follow the state being entered, so the locking token is already decoded.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= SEARCH;
            r_tokCnt    <= '0;
            r_winCnt    <= '0;
            r_settleCnt <= '0;
            r_gapCnt    <= '0;
            r_data      <= 8'h00;
            r_control   <= 2'b00;
            r_ve        <= 1'b0;
            r_locked    <= 1'b0;
            r_bitslip   <= 1'b0;
        end else begin
            r_state     <= w_nextState;
            r_tokCnt    <= w_tokCnt;
            r_winCnt    <= w_winCnt;
            r_settleCnt <= w_settleCnt;
            r_gapCnt    <= w_gapCnt;
            r_locked    <= (w_nextState == LOCKED);
            r_bitslip   <= w_slip;
            if (w_nextState == LOCKED && w_isTok) begin
                r_data    <= 8'h00;
                r_control <= w_tokVal;
                r_ve      <= 1'b0;
            end else if (w_nextState == LOCKED) begin
                r_data    <= w_q;
                r_control <= 2'b00;
                r_ve      <= 1'b1;
            end else begin
                r_data    <= 8'h00;
                r_control <= 2'b00;
                r_ve      <= 1'b0;
            end
        end
    end

    assign o_data    = r_data;
    assign o_control = r_control;
    assign o_ve      = r_ve;
    assign o_locked  = r_locked;
    assign o_bitslip = r_bitslip;

endmodule

// File: tb/tb_tmds_decoder.sv
// Self-checking bench for tmds_decoder: vector table, encoder-model sweep,
// and hand-written alignment, loss-of-lock and reset sequences.
module tb_tmds_decoder;

    localparam int SW = 4096;
    localparam int SS = 16;
    localparam int LW = 65536;
    localparam logic [9:0] TOK0 = 10'b1101010100;
    localparam logic [9:0] TOK1 = 10'b0010101011;
    localparam logic [9:0] TOK2 = 10'b0101010100;
    localparam logic [9:0] TOK3 = 10'b1010101011;

    logic       clock = 1'b0;
    logic       rst   = 1'b0;
    logic [9:0] word  = 10'h000;
    logic [7:0] oData;
    logic [1:0] oControl;
    logic       oVe;
    logic       oLocked;
    logic       oBitslip;

    int vecCount  = 0;
    int missCount = 0;

    typedef struct {
        logic [9:0] word;
        logic       rst;
        logic [7:0] data;
        logic [1:0] ctrl;
        logic       ve;
        logic       locked;
        logic       slip;
    } vec_t;

    vec_t expQ[$];
    vec_t table_[19];

    tmds_decoder #(
        .LOCK_COUNT(8), .SEARCH_WINDOW(SW), .SLIP_SETTLE(SS), .LOSS_WINDOW(LW)
    ) dut (
        .i_clk(clock), .i_rst(rst), .i_word(word),
        .o_data(oData), .o_control(oControl), .o_ve(oVe),
        .o_locked(oLocked), .o_bitslip(oBitslip)
    );

    always #5 clock = ~clock;

    function automatic vec_t mk(input logic [9:0] w, input logic r, input logic [7:0] d,
                                input logic [1:0] c, input logic v, input logic l, input logic s);
        vec_t t;
        t.word = w; t.rst = r; t.data = d; t.ctrl = c; t.ve = v; t.locked = l; t.slip = s;
        return t;
    endfunction

    // Transmit-side reference encoder, with selectable final inversion.
    function automatic logic [9:0] encodeByte(input logic [7:0] d, input logic inv);
        logic [8:0] qm;
        int         n1;
        logic       useXnor;
        n1 = $countones(d);
        useXnor = (n1 > 4) || (n1 == 4 && d[0] == 1'b0);
        qm[0] = d[0];
        for (int i = 1; i < 8; i++)
            qm[i] = useXnor ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
        qm[8] = ~useXnor;
        return inv ? {1'b1, qm[8], ~qm[7:0]} : {1'b0, qm[8], qm[7:0]};
    endfunction

    function automatic logic [9:0] rotl(input logic [9:0] w, input int n);
        return (w << n) | (w >> (10 - n));
    endfunction

    task automatic checkVal(input string name, input int got, input int want);
        vecCount++;
        if (got != want) begin
            missCount++;
            $display("[TB] FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    task automatic checkOutput(input string name);
        vec_t e;
        e = expQ.pop_front();
        vecCount++;
        if (oData !== e.data || oControl !== e.ctrl || oVe !== e.ve ||
            oLocked !== e.locked || oBitslip !== e.slip) begin
            missCount++;
            $display("[TB] FAIL %s word=%b: got data=%h ctrl=%b ve=%b locked=%b slip=%b, want data=%h ctrl=%b ve=%b locked=%b slip=%b",
                     name, e.word, oData, oControl, oVe, oLocked, oBitslip,
                     e.data, e.ctrl, e.ve, e.locked, e.slip);
        end
    endtask

    task automatic applyStimulus(input vec_t v, input string name);
        rst  = v.rst;
        word = v.word;
        expQ.push_back(v);
        @(posedge clock);
        #1;
        checkOutput(name);
        rst = 1'b0;
    endtask

    task automatic doReset();
        rst  = 1'b1;
        word = 10'h155;
        repeat (3) begin
            @(posedge clock);
            #1;
        end
        rst = 1'b0;
    endtask

    initial begin
        int pulseAt[$];
        int off;
        int lockCycle;
        int badOut;
        int badLoss;

        table_[0]  = mk(10'h2AB, 1, 8'h00, 2'b00, 0, 0, 0);
        table_[1]  = mk(TOK0,    1, 8'h00, 2'b00, 0, 0, 0);
        table_[2]  = mk(10'h3FF, 1, 8'h00, 2'b00, 0, 0, 0);
        for (int i = 3; i < 10; i++) table_[i] = mk(TOK0, 0, 8'h00, 2'b00, 0, 0, 0);
        table_[10] = mk(TOK0,    0, 8'h00, 2'b00, 0, 1, 0);
        table_[11] = mk(TOK1,    0, 8'h00, 2'b01, 0, 1, 0);
        table_[12] = mk(TOK2,    0, 8'h00, 2'b10, 0, 1, 0);
        table_[13] = mk(TOK3,    0, 8'h00, 2'b11, 0, 1, 0);
        table_[14] = mk(10'h100, 0, 8'h00, 2'b00, 1, 1, 0);
        table_[15] = mk(10'h3FF, 0, 8'h00, 2'b00, 1, 1, 0);
        table_[16] = mk(10'h0FF, 0, 8'hFF, 2'b00, 1, 1, 0);
        table_[17] = mk(10'h2AA, 0, 8'h01, 2'b00, 1, 1, 0);
        table_[18] = mk(TOK1,    1, 8'h00, 2'b00, 0, 0, 0);

        for (int i = 0; i < 19; i++) applyStimulus(table_[i], $sformatf("table[%0d]", i));

        // Interrupted search: the data word must restart the token count.
        for (int i = 0; i < 7; i++) applyStimulus(mk(TOK0, 0, 8'h00, 2'b00, 0, 0, 0), "interrupt-a");
        applyStimulus(mk(10'h100, 0, 8'h00, 2'b00, 0, 0, 0), "interrupt-data");
        for (int i = 0; i < 7; i++) applyStimulus(mk(TOK0, 0, 8'h00, 2'b00, 0, 0, 0), "interrupt-b");
        applyStimulus(mk(TOK0, 0, 8'h00, 2'b00, 0, 1, 0), "interrupt-lock");

        for (int b = 0; b < 256; b++)
            for (int p = 0; p < 2; p++)
                applyStimulus(mk(encodeByte(8'(b), p[0]), 0, 8'(b), 2'b00, 1, 1, 0),
                              $sformatf("decode b=%0d inv=%0d", b, p));

        // Misaligned stream: each slip pulse shifts our model framing back by one bit.
        doReset();
        off = 3; lockCycle = 0; badOut = 0;
        for (int c = 1; c <= 20000; c++) begin
            word = rotl(TOK0, off);
            @(posedge clock);
            #1;
            if (oBitslip) begin
                pulseAt.push_back(c);
                if (off > 0) off--;
            end
            if (!oLocked && (oVe || oData != 8'h00 || oControl != 2'b00)) badOut++;
            if (oLocked) begin
                lockCycle = c;
                break;
            end
        end
        checkVal("slip-count", pulseAt.size(), 3);
        for (int k = 0; k < 3; k++)
            if (k < pulseAt.size())
                checkVal($sformatf("slip[%0d]-cycle", k), pulseAt[k], SW + k * (SW + SS));
        checkVal("misalign-lock-cycle", lockCycle, SW + 2 * (SW + SS) + SS + 8);
        checkVal("unlocked-outputs-zero", badOut, 0);

        // Loss of lock after LOSS_WINDOW words without a token.
        badLoss = 0;
        for (int i = 0; i < LW - 1; i++) begin
            word = 10'h100;
            @(posedge clock);
            #1;
            if (!oLocked || !oVe || oBitslip) badLoss++;
        end
        checkVal("lock-held-in-window", badLoss, 0);
        applyStimulus(mk(10'h100, 0, 8'h00, 2'b00, 0, 0, 0), "loss-drop");

        badLoss = 0;
        for (int i = 0; i < SW - 1; i++) begin
            word = 10'h100;
            @(posedge clock);
            #1;
            if (oBitslip || oLocked) badLoss++;
        end
        checkVal("post-loss-no-slip", badLoss, 0);
        applyStimulus(mk(10'h100, 0, 8'h00, 2'b00, 0, 0, 1), "post-loss-slip");

        // Reset inside SLIP_WAIT must return straight to SEARCH.
        applyStimulus(mk(TOK0, 1, 8'h00, 2'b00, 0, 0, 0), "reset-in-slipwait");
        for (int i = 0; i < 7; i++) applyStimulus(mk(TOK0, 0, 8'h00, 2'b00, 0, 0, 0), "after-reset");
        applyStimulus(mk(TOK0, 0, 8'h00, 2'b00, 0, 1, 0), "after-reset-lock");

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule

// File: doc/tmds_decoder.md
Name: tmds_decoder

Overview:
Receive-side counterpart of the channel TMDS encoder. Takes one 10-bit parallel TMDS word per pixel clock from an external deserializer and aligns the word boundary by requesting bit-slips until control tokens are reliably seen. Once aligned, it decodes 8-bit video data, 2-bit control and the video-enable flag. One instance per channel (R/G/B); on blue, o_control carries {vs,hs}.

Parameters:
LOCK_COUNT, 8, consecutive valid control tokens required to declare lock
SEARCH_WINDOW, 4096, words examined in SEARCH before requesting a bit-slip
SLIP_SETTLE, 16, words ignored after a bit-slip pulse while the deserializer re-frames
LOSS_WINDOW, 65536, words allowed in LOCKED without any control token before lock is dropped

Ports:
i_clk  input  1  pixel clock
i_rst  input  1  synchronous, active-high reset
i_word  input  10  raw TMDS word from deserializer, bit 9 = last-transmitted MSB as produced by encoder
o_data  output  8  decoded video byte
o_control  output  2  decoded control value ({vs,hs} on blue)
o_ve  output  1  1 = o_data valid video, 0 = control period
o_locked  output  1  word alignment achieved
o_bitslip  output  1  one-cycle request to deserializer to shift framing by one bit

Behaviour:
- Reset: i_rst (synchronous, active-high) on i_clk; all outputs 0; FSM = SEARCH; all counters 0. Reset mid-operation aborts any slip/lock immediately.
- Control tokens (exact match on i_word): 10'b1101010100 -> 00, 10'b0010101011 -> 01, 10'b0101010100 -> 10, 10'b1010101011 -> 11.
- Data decode: d = i_word[9] ? {i_word[8], ~i_word[7:0]} : i_word[8:0]. q[0] = d[0]. For i = 1..7: q[i] = d[8] ? d[i]^d[i-1] : ~(d[i]^d[i-1]).
- Latency: one register stage. i_word sampled at edge N -> o_data/o_control/o_ve valid after edge N.
- Output rules when o_locked=1: token -> o_ve=0, o_control=token value, o_data=0. Non-token -> o_ve=1, o_data=q, o_control=0.
- Output rules when not locked (incl. SLIP_WAIT): o_ve=0, o_data=0, o_control=0.
- FSM SEARCH:
  - tok_cnt increments on each token and clears on each non-token.
  - win_cnt increments every word.
  - tok_cnt reaching LOCK_COUNT -> LOCKED, o_locked=1 from the next cycle. The LOCK_COUNT-th token's output is already decoded.
  - Else win_cnt reaching SEARCH_WINDOW-1 -> o_bitslip=1 for exactly one cycle, clear counters, -> SLIP_WAIT.
- FSM SLIP_WAIT: ignore i_word for SLIP_SETTLE cycles, then -> SEARCH with counters cleared. o_bitslip is never asserted outside the SEARCH->SLIP_WAIT transition.
- FSM LOCKED:
  - gap_cnt clears on every token and increments otherwise.
  - gap_cnt reaching LOSS_WINDOW-1 -> SEARCH, o_locked=0 next cycle, counters cleared, no slip pulse.
- Simultaneous events: in SEARCH, lock condition beats window expiry in the same cycle.
- Counter widths: $clog2 of the respective parameter, plus 1. Counters saturate and never wrap.
- Bit-slip: at most one slip per SEARCH_WINDOW+SLIP_SETTLE cycles, and slipping continues indefinitely while no lock is achieved.

Test Plan:
- Reset: hold i_rst 3 cycles with arbitrary i_word -> all outputs 0, o_bitslip never pulses.
- Lock: feed 8 consecutive 10'b1101010100 -> o_locked=1 after the 8th word's edge + 1, o_ve=0, o_control=00. Feed 10'b0010101011 -> o_control=01.
- Data decode: locked, feed 10'h100 then 10'h3FF -> o_data=8'h00, o_ve=1 both. Drive all 256 bytes through a reference encoder model (both parity choices) -> o_data matches input, 1-cycle latency.
- Misalignment: feed a control token stream rotated by 3 bits; bench rotates back by 1 bit per o_bitslip pulse -> exactly 3 pulses, spaced SEARCH_WINDOW+SLIP_SETTLE apart, then lock.
- Interrupted search: 7 tokens, 1 data word, then 8 tokens -> lock only after the final 8th token.
- Loss of lock: locked, then LOSS_WINDOW data words with no token -> o_locked falls, o_ve=0. Assert i_rst mid-SLIP_WAIT -> SEARCH, outputs 0.
